// File: rtl/gradient_write_sink_if.sv
// Gradient memory-write handshake: {address, value, valid} from the arbiter, ready back from the sink.
interface gradient_write_sink_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int VALUE_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]         mem_address;
    logic signed [VALUE_WIDTH-1:0] mem_value;
    logic                          mem_valid;
    logic                          mem_ready;

    modport master (
        output mem_address,
        output mem_value,
        output mem_valid,
        input  mem_ready
    );

    modport slave (
        input  mem_address,
        input  mem_value,
        input  mem_valid,
        output mem_ready
    );
endinterface

// File: rtl/gradient_write_sink.sv
// Gradient write sink: FIFO-buffered updates accumulated into parameter SRAM by saturating read-modify-write.
// Optional statistics counters are enabled by defining GRAD_SINK_STATS_EN.
module gradient_write_sink #(
    parameter int ADDR_WIDTH  = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int MEM_AW      = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    gradient_write_sink_if.slave          mem,
    output logic [MEM_AW-1:0]             sram_addr,
    output logic                          sram_rd_en,
    input  logic signed [VALUE_WIDTH-1:0] sram_rdata,
    output logic                          sram_we,
    output logic [VALUE_WIDTH-1:0]        sram_wdata,
    output logic                          busy,
    output logic                          addr_err
`ifdef GRAD_SINK_STATS_EN
    ,
    output logic [31:0]                   stat_accepted,
    output logic [15:0]                   stat_dropped,
    output logic [15:0]                   stat_saturated
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ACC
    } state_t;

    state_t state, state_next;

    logic [MEM_AW-1:0]      fifo_idx   [FIFO_DEPTH];
    logic [VALUE_WIDTH-1:0] fifo_delta [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;

    logic [MEM_AW-1:0]      idx_q;
    logic [VALUE_WIDTH-1:0] delta_q;

    logic full, empty, handshake, addr_bad, push, pop;
    logic [VALUE_WIDTH:0]   sum_ext;
    logic                   overflow;
    logic [VALUE_WIDTH-1:0] sat_sum;

    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign mem.mem_ready = !reset && !full;
    assign handshake = mem.mem_valid && mem.mem_ready;
    assign addr_bad  = (mem.mem_address >> MEM_AW) != '0;
    assign push      = handshake && !addr_bad;

    // Sign-extend both operands one bit so overflow shows as disagreement of the top two bits.
    assign sum_ext  = {sram_rdata[VALUE_WIDTH-1], sram_rdata} + {delta_q[VALUE_WIDTH-1], delta_q};
    assign overflow = sum_ext[VALUE_WIDTH] != sum_ext[VALUE_WIDTH-1];
    assign sat_sum  = !overflow ? sum_ext[VALUE_WIDTH-1:0]
                    : sum_ext[VALUE_WIDTH] ? {1'b1, {(VALUE_WIDTH-1){1'b0}}}
                    :                        {1'b0, {(VALUE_WIDTH-1){1'b1}}};

    assign busy = !reset && (!empty || state != S_IDLE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        sram_rd_en = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    sram_rd_en = 1'b1;
                    sram_addr  = fifo_idx[rd_ptr];
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                sram_we    = 1'b1;
                sram_addr  = idx_q;
                sram_wdata = sat_sum;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Strobes are suppressed during reset so an in-flight write is abandoned.
        if (reset) begin
            pop        = 1'b0;
            sram_rd_en = 1'b0;
            sram_we    = 1'b0;
            sram_addr  = '0;
            sram_wdata = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx_q    <= '0;
            delta_q  <= '0;
            addr_err <= 1'b0;
        end else begin
            state <= state_next;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (push) begin
                fifo_idx[wr_ptr]   <= mem.mem_address[MEM_AW-1:0];
                fifo_delta[wr_ptr] <= mem.mem_value;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                idx_q   <= fifo_idx[rd_ptr];
                delta_q <= fifo_delta[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (handshake && addr_bad)
                addr_err <= 1'b1;
        end
    end

`ifdef GRAD_SINK_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_accepted  <= '0;
            stat_dropped   <= '0;
            stat_saturated <= '0;
        end else begin
            if (handshake && stat_accepted != '1)
                stat_accepted <= stat_accepted + 1'b1;
            if (handshake && addr_bad && stat_dropped != '1)
                stat_dropped <= stat_dropped + 1'b1;
            if (state == S_ACC && overflow && stat_saturated != '1)
                stat_saturated <= stat_saturated + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gradient_write_sink.sv
// Bench for gradient_write_sink: directed cases plus randomized updates against an arithmetic reference model.
module tb_gradient_write_sink;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    gradient_write_sink_if #(.ADDR_WIDTH(32), .VALUE_WIDTH(16)) mem_if ();

    logic [9:0]  sram_addr;
    logic        sram_rd_en;
    logic [15:0] sram_rdata;
    logic        sram_we;
    logic [15:0] sram_wdata;
    logic        busy;
    logic        addr_err;
`ifdef GRAD_SINK_STATS_EN
    logic [31:0] stat_accepted;
    logic [15:0] stat_dropped;
    logic [15:0] stat_saturated;
`endif

    gradient_write_sink #(
        .ADDR_WIDTH(32),
        .VALUE_WIDTH(16),
        .MEM_AW(10),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem(mem_if),
        .sram_addr(sram_addr),
        .sram_rd_en(sram_rd_en),
        .sram_rdata(sram_rdata),
        .sram_we(sram_we),
        .sram_wdata(sram_wdata),
        .busy(busy),
        .addr_err(addr_err)
`ifdef GRAD_SINK_STATS_EN
        ,
        .stat_accepted(stat_accepted),
        .stat_dropped(stat_dropped),
        .stat_saturated(stat_saturated)
`endif
    );

    // SRAM behavioural model with a bench-side preload/clear port.
    logic [15:0] sram [1024];
    logic        clr = 1'b0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clock) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) sram[i] <= '0;
        end else if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else begin
            if (sram_rd_en) sram_rdata <= sram[sram_addr];
            if (sram_we) sram[sram_addr] <= sram_wdata;
        end
    end

    // Reference model: memory image and ordered list of expected writes.
    typedef struct {
        int addr;
        int val;
    } wr_t;

    wr_t wq[$];
    int  refmem [1024];
    logic exp_err = 1'b0;
    int  exp_accepted = 0;
    int  exp_dropped = 0;
    int  exp_saturated = 0;
    int  checks = 0;
    int  errors = 0;
    logic ever_low = 1'b0;

    function automatic int sat16(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [31:0] addr, input logic signed [15:0] val);
        int idx;
        int raw;
        exp_accepted++;
        if ((addr >> 10) != 0) begin
            exp_err = 1'b1;
            exp_dropped++;
        end else begin
            idx = int'(addr);
            raw = refmem[idx] + int'(val);
            if (sat16(raw) != raw) exp_saturated++;
            refmem[idx] = sat16(raw);
            wq.push_back('{addr: idx, val: sat16(raw)});
        end
    endtask

    always @(negedge clock) begin
        if (sram_we) begin
            checks++;
            assert (wq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=addr %0h data %0h expected=no write", sram_addr, sram_wdata);
            end
            if (wq.size() != 0) begin
                wr_t e;
                e = wq.pop_front();
                chk("write_addr", 32'(sram_addr), 32'(e.addr));
                chk("write_data", 32'(sram_wdata), 32'(e.val) & 32'hFFFF);
            end
        end
    end

    task automatic push(input logic [31:0] addr, input logic signed [15:0] val, input bit use_model);
        bit done = 0;
        @(negedge clock);
        mem_if.mem_valid   = 1'b1;
        mem_if.mem_address = addr;
        mem_if.mem_value   = val;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (mem_if.mem_ready) begin
                if (use_model) model_accept(addr, val);
                @(posedge clock);
                #1 mem_if.mem_valid = 1'b0;
                done = 1;
            end else begin
                ever_low = 1'b1;
                @(negedge clock);
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL push_timeout observed=not accepted expected=accepted addr %0h", addr);
            mem_if.mem_valid = 1'b0;
        end
    endtask

    task automatic preload(input int a, input logic signed [15:0] d);
        @(negedge clock);
        pl_en = 1'b1;
        pl_addr = 10'(a);
        pl_data = d;
        @(posedge clock);
        #1 pl_en = 1'b0;
        refmem[a] = int'(d);
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || busy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_within_budget", 32'(n < 200), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        mem_if.mem_valid = 1'b0;
        clr = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clr = 1'b0;
        chk("rst_ready", 32'(mem_if.mem_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {30'd0, sram_rd_en, sram_we}, 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        wq.delete();
        for (int i = 0; i < 1024; i++) refmem[i] = 0;
        exp_err = 1'b0;
        exp_accepted = 0;
        exp_dropped = 0;
        exp_saturated = 0;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("idle_ready", 32'(mem_if.mem_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_strobes", {20'd0, sram_addr, sram_rd_en, sram_we}, 32'd0);
    endtask

    initial begin
        mem_if.mem_valid   = 1'b0;
        mem_if.mem_address = '0;
        mem_if.mem_value   = '0;

        do_reset();

        // Single update latency and value.
        preload(5, 16'sd100);
        push(32'd5, -16'sd30, 1);
        @(negedge clock);
        chk("lat_rd_en", 32'(sram_rd_en), 32'd1);
        chk("lat_rd_addr", 32'(sram_addr), 32'd5);
        chk("lat_no_we", 32'(sram_we), 32'd0);
        @(negedge clock);
        chk("lat_we", 32'(sram_we), 32'd1);
        chk("lat_wr_addr", 32'(sram_addr), 32'd5);
        chk("lat_wdata", 32'(sram_wdata), 32'd70);
        drain();

        // Back-to-back same address accumulates both deltas.
        push(32'd7, 16'sd10, 1);
        push(32'd7, 16'sd20, 1);
        drain();
        chk("same_addr_final", 32'(sram[7]), 32'd30);

        // Positive and negative saturation.
        preload(3, 16'sd32760);
        push(32'd3, 16'sd100, 1);
        drain();
        chk("sat_pos", 32'(sram[3]), 32'h7FFF);
        preload(3, -16'sd32760);
        push(32'd3, -16'sd100, 1);
        drain();
        chk("sat_neg", 32'(sram[3]), 32'h8000);

        // Backpressure: continuous valid with distinct addresses.
        ever_low = 1'b0;
        for (int i = 0; i < 12; i++) push(32'(100 + i), 16'(i + 1), 1);
        drain();
        chk("backpressure_seen", 32'(ever_low), 32'd1);
        chk("bp_last_value", 32'(sram[111]), 32'd12);

        // Address error: accepted, not written, sticky.
        chk("pre_err", 32'(addr_err), 32'd0);
        push(32'h0000_0400, 16'sd55, 1);
        repeat (3) @(negedge clock);
        chk("addr_err_set", 32'(addr_err), 32'd1);
        chk("addr_err_idle", 32'(busy), 32'd0);
        chk("addr_err_no_alias", 32'(sram[0]), 32'd0);
`ifdef GRAD_SINK_STATS_EN
        chk("stat_dropped", 32'(stat_dropped), 32'(exp_dropped));
        chk("stat_accepted", stat_accepted, 32'(exp_accepted));
        chk("stat_saturated", 32'(stat_saturated), 32'(exp_saturated));
`endif
        push(32'd9, 16'sd1, 1);
        drain();
        chk("addr_err_sticky", 32'(addr_err), 32'd1);

        // Reset while a read-modify-write is in flight.
        do_reset();
        preload(9, 16'sd50);
        push(32'd9, 16'sd5, 0);
        @(negedge clock);
        chk("midrst_rd_en", 32'(sram_rd_en), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_no_we", 32'(sram_we), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("midrst_mem_kept", 32'(sram[9]), 32'd50);
        chk("midrst_busy", 32'(busy), 32'd0);

        // Randomized updates against the reference model.
        do_reset();
        for (int a = 0; a < 16; a++) begin
            logic [15:0] r;
            r = 16'($urandom);
            preload(a, r);
        end
        for (int n = 0; n < 150; n++) begin
            logic [31:0] addr;
            logic [15:0] v;
            if ($urandom_range(0, 15) == 0) addr = 32'h0000_0400 | 32'($urandom);
            else addr = 32'($urandom_range(0, 15));
            v = 16'($urandom);
            push(addr, v, 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        drain();
        chk("rand_addr_err", 32'(addr_err), 32'(exp_err));
        for (int a = 0; a < 16; a++) chk("rand_mem", 32'(sram[a]), 32'(refmem[a]) & 32'hFFFF);
`ifdef GRAD_SINK_STATS_EN
        chk("rand_stat_accepted", stat_accepted, 32'(exp_accepted));
        chk("rand_stat_dropped", 32'(stat_dropped), 32'(exp_dropped));
        chk("rand_stat_saturated", 32'(stat_saturated), 32'(exp_saturated));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
